// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   size_e      : request access size encoding (2'b11 is illegal, not listed)
//   state_e     : sequencing states of the load/store unit
//   lanes_t     : four memory byte lanes, lane i = byte at aligned address + i
//   is_misaligned(): alignment / legality check of a request
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int DEFAULT_MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10,
        RESP    = 2'b11
    } state_e;

    // Packed so that the whole bundle reads as {lane3, lane2, lane1, lane0}.
    typedef logic [3:0][7:0] lanes_t;

    // A request is rejected when it straddles its natural boundary or when the
    // size field holds the unused encoding.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// Interfaces of the load/store unit.
//
// lsu_core_if : request/response handshake between riscv_core and the LSU.
//   req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata (core->lsu)
//   req_ready, resp_valid, resp_rdata, resp_misaligned                (lsu->core)
//   modport master = core side, modport slave = LSU side.
//
// lsu_mem_if  : word-wide data memory bus with four byte lanes.
//   mem_addr, mem_data_in, mem_write_en (lsu->memory)
//   mem_data_out                        (memory->lsu, already latency-delayed)
//   modport master = LSU side, modport slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_core_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    lsu_pkg::lanes_t   mem_data_in;
    lsu_pkg::lanes_t   mem_data_out;
    logic              mem_write_en;

    modport master (
        output mem_addr, mem_data_in, mem_write_en,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_write_en,
        output mem_data_out
    );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane helper of the load/store unit.
//   chk_size, chk_addr_lo -> misaligned  : legality of an incoming request
//   op_size, op_addr_lo, op_unsigned     : registered request being served
//   rd_lanes                             : word read back from memory
//   load_data                            : extracted and extended load result
//   op_wdata, merged_lanes               : read word with store data merged in
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  chk_size,
    input  logic [1:0]  chk_addr_lo,
    output logic        misaligned,

    input  logic [1:0]  op_size,
    input  logic [1:0]  op_addr_lo,
    input  logic        op_unsigned,
    input  logic [31:0] op_wdata,
    input  lanes_t      rd_lanes,
    output logic [31:0] load_data,
    output lanes_t      merged_lanes
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [1:0]  half_lo_lane;
    logic [1:0]  half_hi_lane;

    assign misaligned = is_misaligned(chk_size, chk_addr_lo);

    // A legal half access only ever sits on lanes {1,0} or {3,2}, so addr[1]
    // alone picks the pair.
    assign half_lo_lane = {op_addr_lo[1], 1'b0};
    assign half_hi_lane = {op_addr_lo[1], 1'b1};

    assign byte_sel = rd_lanes[op_addr_lo];
    assign half_sel = {rd_lanes[half_hi_lane], rd_lanes[half_lo_lane]};

    // Load extraction: shift the selected bytes down and extend them.
    always_comb begin
        load_data = rd_lanes;
        case (op_size)
            SZ_BYTE: load_data = op_unsigned ? {24'h0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = op_unsigned ? {16'h0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: load_data = rd_lanes;
        endcase
    end

    // Store merge: only the addressed lanes take the new data, the rest keep
    // what was read so the write-back leaves neighbouring bytes intact.
    always_comb begin
        merged_lanes = rd_lanes;
        case (op_size)
            SZ_BYTE: merged_lanes[op_addr_lo] = op_wdata[7:0];
            SZ_HALF: begin
                merged_lanes[half_lo_lane] = op_wdata[7:0];
                merged_lanes[half_hi_lane] = op_wdata[15:8];
            end
            default: merged_lanes = op_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges riscv_core load/store requests onto a word-wide data memory whose
// read data and write data/enable both pass through MEM_LATENCY registers.
//   clk, rst_b : clock and asynchronous active-low reset
//   core       : lsu_core_if.slave  request/response handshake with the core
//   mem        : lsu_mem_if.master  word address, byte lanes, write enable
// Loads:            IDLE -> RD_WAIT -> RESP
// Word stores:      IDLE -> WR_WAIT -> RESP
// Sub-word stores:  IDLE -> RD_WAIT -> WR_WAIT -> RESP (read-modify-write)
// Bad requests:     IDLE -> RESP with resp_misaligned, memory untouched
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int ADDR_W      = 32
)(
    input  logic       clk,
    input  logic       rst_b,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    // The wait counter must reach MEM_LATENCY inclusive.
    localparam int              CNT_W    = $clog2(MEM_LATENCY + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ready_q;

    logic              write_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [1:0]        offset_q;
    logic [31:0]       wdata_q;
    logic              misaligned_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] addr_q;
    lanes_t            wlanes_q;

    logic              accept;
    logic              sample_rd;
    logic              req_misaligned;
    logic              req_word_store;
    logic [31:0]       load_data;
    lanes_t            merged_lanes;

    lsu_align u_align (
        .chk_size     (core.req_size),
        .chk_addr_lo  (core.req_addr[1:0]),
        .misaligned   (req_misaligned),
        .op_size      (size_q),
        .op_addr_lo   (offset_q),
        .op_unsigned  (unsigned_q),
        .op_wdata     (wdata_q),
        .rd_lanes     (mem.mem_data_out),
        .load_data    (load_data),
        .merged_lanes (merged_lanes)
    );

    assign accept         = core.req_valid & ready_q;
    assign req_word_store = core.req_write & (core.req_size == SZ_WORD);

    // Next-state logic. Both wait states run the counter from 0 up to
    // MEM_LATENCY: in RD_WAIT that is the cycle whose closing edge captures the
    // delayed read data, in WR_WAIT it is the cycle in which the delayed write
    // enable reaches the memory while mem_addr is still held.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_rd = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (req_misaligned) begin
                        state_d = RESP;
                    end else if (req_word_store) begin
                        state_d = WR_WAIT;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    sample_rd = 1'b1;
                    cnt_d     = '0;
                    state_d   = write_q ? WR_WAIT : RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and ready register. Ready is registered from the next
    // state so it is low throughout reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == IDLE);
        end
    end

    // Request capture and datapath registers. A rejected request must not
    // move mem_addr or the write lanes, so those only load for legal requests.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            offset_q     <= 2'b00;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wlanes_q     <= '0;
        end else begin
            if (accept) begin
                write_q      <= core.req_write;
                size_q       <= core.req_size;
                unsigned_q   <= core.req_unsigned;
                offset_q     <= core.req_addr[1:0];
                wdata_q      <= core.req_wdata;
                misaligned_q <= req_misaligned;
                rdata_q      <= '0;
                if (!req_misaligned) begin
                    addr_q <= {core.req_addr[ADDR_W-1:2], 2'b00};
                end
                if (!req_misaligned && req_word_store) begin
                    wlanes_q <= core.req_wdata;
                end
            end
            if (sample_rd) begin
                if (write_q) begin
                    wlanes_q <= merged_lanes;
                end else begin
                    rdata_q <= load_data;
                end
            end
        end
    end

    assign core.req_ready       = ready_q;
    assign core.resp_valid      = (state_q == RESP);
    assign core.resp_rdata      = (state_q == RESP) ? rdata_q : 32'h0;
    assign core.resp_misaligned = (state_q == RESP) & misaligned_q;

    // The enable is a single pulse on entry to WR_WAIT; the memory's own delay
    // stages stretch it out to the write that lands MEM_LATENCY cycles later.
    assign mem.mem_addr     = addr_q;
    assign mem.mem_data_in  = wlanes_q;
    assign mem.mem_write_en = (state_q == WR_WAIT) && (cnt_q == '0);

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed table-driven bench for load_store_unit, with a behavioural data
// memory that delays read data and write data/enable by MEM_LATENCY cycles,
// plus hand-written reset sequences.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_LATENCY = 4;
    localparam int ADDR_W      = 32;
    localparam int LAT_SHORT   = MEM_LATENCY + 2;
    localparam int LAT_RMW     = 2 * MEM_LATENCY + 3;
    localparam int WE_RMW      = MEM_LATENCY + 2;
    localparam int BUDGET      = 40;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    lsu_core_if #(.ADDR_W(ADDR_W)) cif ();
    lsu_mem_if  #(.ADDR_W(ADDR_W)) mif ();

    load_store_unit #(
        .MEM_LATENCY (MEM_LATENCY),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .core  (cif),
        .mem   (mif)
    );

    // Data memory: combinational read then MEM_LATENCY registers; write data
    // and enable pass through the same depth and use the current address.
    logic [31:0] mem_words [0:255] = '{64: 32'h8899AABB, 65: 32'h00000000,
                                       128: 32'hCAFEF00D, default: 32'h0};
    logic [MEM_LATENCY-1:0][31:0] rd_pipe = '0;
    logic [MEM_LATENCY-1:0][31:0] wd_pipe = '0;
    logic [MEM_LATENCY-1:0]       we_pipe = '0;

    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[MEM_LATENCY-2:0], mem_words[mif.mem_addr[9:2]]};
        wd_pipe <= {wd_pipe[MEM_LATENCY-2:0], 32'(mif.mem_data_in)};
        we_pipe <= {we_pipe[MEM_LATENCY-2:0], mif.mem_write_en};
        if (we_pipe[MEM_LATENCY-1]) begin
            mem_words[mif.mem_addr[9:2]] <= wd_pipe[MEM_LATENCY-1];
        end
    end

    assign mif.mem_data_out = rd_pipe[MEM_LATENCY-1];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_we_k;
    } vec_t;

    vec_t        vecs[$];
    int          errors    = 0;
    int          checks    = 0;
    logic [31:0] last_addr = 32'h0;

    function automatic vec_t mkVec(input logic wr, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int exp_lat,
                                   input logic [31:0] exp_rdata, input logic exp_mis,
                                   input int exp_we_k);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
        v.exp_we_k = exp_we_k;
        return v;
    endfunction

    task automatic checkOutput(input string what, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (vec %0d): got 0x%08h, expected 0x%08h",
                     what, idx, actual, expected);
        end
    endtask

    // Issues one request, follows it cycle by cycle until the response and
    // checks latency, result, write-enable timing and address hold.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          waited;
        int          lat;
        int          we_k;
        int          we_cnt;
        int          hold_bad;
        int          ready_bad;
        bit          got_resp;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] exp_addr;

        exp_addr = v.exp_mis ? last_addr : {v.addr[31:2], 2'b00};
        waited   = 0;
        @(negedge clk);
        while (cif.req_ready !== 1'b1 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_req", idx, 32'(cif.req_ready), 32'h1);

        cif.req_valid    = 1'b1;
        cif.req_write    = v.wr;
        cif.req_size     = v.size;
        cif.req_unsigned = v.uns;
        cif.req_addr     = v.addr;
        cif.req_wdata    = v.wdata;
        @(posedge clk);
        @(negedge clk);
        cif.req_valid = 1'b0;

        got_resp = 1'b0; lat = 0; we_k = 0; we_cnt = 0;
        hold_bad = 0; ready_bad = 0; rdata = 32'h0; mis = 1'b0;
        for (int c = 1; c <= BUDGET && !got_resp; c++) begin
            if (mif.mem_write_en === 1'b1) begin
                we_cnt++;
                if (we_k == 0) we_k = c;
            end
            if (mif.mem_addr !== exp_addr) hold_bad++;
            if (cif.req_ready !== 1'b0) ready_bad++;
            if (cif.resp_valid === 1'b1) begin
                got_resp = 1'b1;
                lat      = c;
                rdata    = cif.resp_rdata;
                mis      = cif.resp_misaligned;
            end else begin
                @(negedge clk);
            end
        end

        checkOutput("latency", idx, 32'(lat), 32'(v.exp_lat));
        checkOutput("rdata", idx, rdata, v.exp_rdata);
        checkOutput("misaligned", idx, 32'(mis), 32'(v.exp_mis));
        checkOutput("we_cycle", idx, 32'(we_k), 32'(v.exp_we_k));
        checkOutput("we_count", idx, 32'(we_cnt), (v.exp_we_k != 0) ? 32'h1 : 32'h0);
        checkOutput("addr_hold_bad_cycles", idx, 32'(hold_bad), 32'h0);
        checkOutput("ready_busy_bad_cycles", idx, 32'(ready_bad), 32'h0);

        @(negedge clk);
        checkOutput("after_resp_{valid,ready}", idx,
                    32'({cif.resp_valid, cif.req_ready}), 32'h1);

        if (!v.exp_mis) last_addr = exp_addr;
    endtask

    task automatic checkResetOutputs(input int idx);
        checkOutput("rst_req_ready", idx, 32'(cif.req_ready), 32'h0);
        checkOutput("rst_resp_valid", idx, 32'(cif.resp_valid), 32'h0);
        checkOutput("rst_resp_rdata", idx, cif.resp_rdata, 32'h0);
        checkOutput("rst_resp_misaligned", idx, 32'(cif.resp_misaligned), 32'h0);
        checkOutput("rst_mem_addr", idx, mif.mem_addr, 32'h0);
        checkOutput("rst_mem_data_in", idx, 32'(mif.mem_data_in), 32'h0);
        checkOutput("rst_mem_write_en", idx, 32'(mif.mem_write_en), 32'h0);
        checkOutput("rst_state", idx, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        int resp_seen;
        int we_seen;

        cif.req_valid    = 1'b0;
        cif.req_write    = 1'b0;
        cif.req_size     = 2'b00;
        cif.req_unsigned = 1'b0;
        cif.req_addr     = 32'h0;
        cif.req_wdata    = 32'h0;

        //                wr    size     uns   addr          wdata         lat        rdata          mis   we_k
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0,        LAT_SHORT, 32'h8899AABB, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_BYTE, 1'b0, 32'h0000_0101, 32'h0,        LAT_SHORT, 32'hFFFFFFAA, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_BYTE, 1'b1, 32'h0000_0101, 32'h0,        LAT_SHORT, 32'h000000AA, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_HALF, 1'b1, 32'h0000_0102, 32'h0,        LAT_SHORT, 32'h00008899, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_HALF, 1'b0, 32'h0000_0102, 32'h0,        LAT_SHORT, 32'hFFFF8899, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0,        LAT_SHORT, 32'hFFFFFF88, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_HALF, 1'b0, 32'h0000_0100, 32'h0,        LAT_SHORT, 32'hFFFFAABB, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_BYTE, 1'b1, 32'h0000_0100, 32'h0,        LAT_SHORT, 32'h000000BB, 1'b0, 0));
        vecs.push_back(mkVec(1'b1, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h12,       LAT_RMW,   32'h0,        1'b0, WE_RMW));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0,        LAT_SHORT, 32'h1299AABB, 1'b0, 0));
        vecs.push_back(mkVec(1'b1, SZ_WORD, 1'b0, 32'h0000_0104, 32'hDEADBEEF, LAT_SHORT, 32'h0,        1'b0, 1));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0,        LAT_SHORT, 32'hDEADBEEF, 1'b0, 0));
        vecs.push_back(mkVec(1'b1, SZ_HALF, 1'b0, 32'h0000_0106, 32'h1234,     LAT_RMW,   32'h0,        1'b0, WE_RMW));
        vecs.push_back(mkVec(1'b1, SZ_BYTE, 1'b0, 32'h0000_0101, 32'h7F,       LAT_RMW,   32'h0,        1'b0, WE_RMW));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0,        LAT_SHORT, 32'h12997FBB, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0,        LAT_SHORT, 32'h1234BEEF, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_HALF, 1'b0, 32'h0000_0104, 32'h0,        LAT_SHORT, 32'hFFFFBEEF, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_HALF, 1'b1, 32'h0000_0106, 32'h0,        LAT_SHORT, 32'h00001234, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0102, 32'h0,        1,         32'h0,        1'b1, 0));
        vecs.push_back(mkVec(1'b1, SZ_HALF, 1'b0, 32'h0000_0101, 32'hFFFF,     1,         32'h0,        1'b1, 0));
        vecs.push_back(mkVec(1'b0, 2'b11,   1'b0, 32'h0000_0100, 32'h0,        1,         32'h0,        1'b1, 0));
        vecs.push_back(mkVec(1'b1, 2'b11,   1'b0, 32'h0000_0104, 32'h0,        1,         32'h0,        1'b1, 0));
        vecs.push_back(mkVec(1'b1, SZ_WORD, 1'b0, 32'h0000_0101, 32'hAAAAAAAA, 1,         32'h0,        1'b1, 0));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0,        LAT_SHORT, 32'h12997FBB, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0,        LAT_SHORT, 32'h1234BEEF, 1'b0, 0));

        // Power-on reset: everything at zero while rst_b is low.
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs(-1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Abort a half store in the middle of its read phase (cycle T+3).
        $display("[TB] reset during sh 0x200");
        @(negedge clk);
        checkOutput("rst_seq_ready", 100, 32'(cif.req_ready), 32'h1);
        cif.req_valid    = 1'b1;
        cif.req_write    = 1'b1;
        cif.req_size     = SZ_HALF;
        cif.req_unsigned = 1'b0;
        cif.req_addr     = 32'h0000_0200;
        cif.req_wdata    = 32'h5555;
        @(posedge clk);
        @(negedge clk);
        cif.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_seq_busy_state", 100, 32'(dut.state_q), 32'(RD_WAIT));
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checkResetOutputs(100);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        resp_seen = 0;
        we_seen   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cif.resp_valid === 1'b1) resp_seen++;
            if (mif.mem_write_en === 1'b1) we_seen++;
        end
        checkOutput("rst_seq_resp_after_release", 100, 32'(resp_seen), 32'h0);
        checkOutput("rst_seq_we_after_release", 100, 32'(we_seen), 32'h0);
        checkOutput("rst_seq_ready_after_release", 100, 32'(cif.req_ready), 32'h1);
        last_addr = 32'h0;

        applyStimulus(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0200, 32'h0, LAT_SHORT,
                            32'hCAFEF00D, 1'b0, 0), 101);
        applyStimulus(mkVec(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, LAT_SHORT,
                            32'h12997FBB, 1'b0, 0), 102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
